// File: rtl/generador_estimulos_ab.sv
// generador_estimulos_ab: on-chip stimulus sequencer for a small combinational block.
// It walks stim_out through 0..2^N_IN-1 and holds each value for DWELL clocks.
// In the last dwell cycle of each value it samples f_in, building the truth table
// in tt_out.
// Optional feature: define SEQ_LOOP_EN so that a held start runs back-to-back
// sweeps with no idle clock between them.
module generador_estimulos_ab #(
  parameter int N_IN  = 2,
  parameter int DWELL = 10,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 f_in,
  output logic [N_IN-1:0]      stim_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt_out,
  output logic                 tt_valid
);

  // A DWELL of zero behaves exactly like one clock per combination.
  localparam int               DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_EFF - 1);
  localparam logic [N_IN-1:0]  STIM_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [N_IN-1:0]      stim_q;
  logic [N_IN-1:0]      stim_d;
  logic [2**N_IN-1:0]   tt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 tt_valid_q;

  // Next values of the dwell counter and the stimulus index.
  // The stimulus index is only advanced below its terminal value, so it never wraps.
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign stim_d = stim_q + N_IN'(1);

  // Sequencer FSM: every output is driven from a register in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      stim_q     <= '0;
      tt_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            stim_q     <= '0;
            tt_q       <= '0;
            tt_valid_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_LAST) begin
            // The DUT has had DWELL-1 clocks to settle, so f_in is sampled now.
            tt_q[stim_q] <= f_in;
            cnt_q        <= '0;
            if (stim_q == STIM_LAST) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              tt_valid_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              stim_q <= stim_d;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
`ifdef SEQ_LOOP_EN
          // With start held, the next sweep begins at once.
          // tt_out is kept, and each bit is overwritten at its own sample point.
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stim_out = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt_out   = tt_q;
  assign tt_valid = tt_valid_q;

endmodule

// File: tb/tb_generador_estimulos_ab.sv
// Bench for generador_estimulos_ab.
// Instance A uses DWELL=10 with an XOR model of the DUT.
// Instance B uses DWELL=1 with an AND model of the DUT.
module tb_generador_estimulos_ab;

`ifdef SEQ_LOOP_EN
  localparam int LOOP = 1;
`else
  localparam int LOOP = 0;
`endif

  typedef struct {
    logic [3:0] tt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       f_a, f_b;
  logic [1:0] stim_a, stim_b;
  logic       busy_a, busy_b, done_a, done_b, ttv_a, ttv_b;
  logic [3:0] tt_a, tt_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Models of the combinational logic under test.
  assign f_a = stim_a[1] ^ stim_a[0];
  assign f_b = stim_b[1] & stim_b[0];

  generador_estimulos_ab #(.N_IN(2), .DWELL(10), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .f_in(f_a), .stim_out(stim_a),
    .busy(busy_a), .done(done_a), .tt_out(tt_a), .tt_valid(ttv_a));

  generador_estimulos_ab #(.N_IN(2), .DWELL(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .f_in(f_b), .stim_out(stim_b),
    .busy(busy_b), .done(done_b), .tt_out(tt_b), .tt_valid(ttv_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h @cyc %0d", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard for instance A.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (qa.size() == 0) begin
        chk("a_done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_done_cyc", cyc, e.cyc);
        chk("a_tt", tt_a, e.tt);
        chk("a_ttvalid", ttv_a, 1);
        chk("a_busy_at_done", busy_a, 0);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (qb.size() == 0) begin
        chk("b_done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_done_cyc", cyc, e.cyc);
        chk("b_tt", tt_b, e.tt);
        chk("b_ttvalid", ttv_b, 1);
      end
    end
  end

  task automatic wait_qa(input int depth, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (qa.size() <= depth) break;
      @(negedge clk); #1;
    end
    chk("a_queue_drained", qa.size(), depth);
  endtask

  // One full sweep on instance A.
  // Optionally pulses start in the middle of RUN, and that pulse must be ignored.
  task automatic sweep_a(input bit inject);
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    qa.push_back('{tt: 4'b0110, cyc: cyc + 40});
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 10; d++) begin
        @(negedge clk);
        chk("a_stim", stim_a, k);
        chk("a_busy", busy_a, 1);
        start_a = inject && (k == 1) && (d == 3);
      end
    end
    wait_qa(0, 5);
    chk("a_tt_hold", tt_a, 4'b0110);
    chk("a_stim_hold", stim_a, 3);
    repeat (15) @(negedge clk);
    chk("a_idle_after", busy_a, 0);
  endtask

  initial begin
    int e1;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;

    // Reset state
    #1;
    chk("rst_stim", stim_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tt", tt_a, 0);
    chk("rst_ttv", ttv_a, 0);
    chk("rst_b_all", {stim_b, busy_b, done_b, tt_b, ttv_b}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_stim", stim_a, 0);
    chk("idle_busy", busy_a, 0);

    // Single XOR sweep
    sweep_a(1'b0);

    // AND model, DWELL=1
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1;
    qb.push_back('{tt: 4'b1000, cyc: cyc + 4});
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_stim", stim_b, k);
    end
    for (int i = 0; i < 5; i++) begin
      if (qb.size() == 0) break;
      @(negedge clk); #1;
    end
    chk("b_queue_drained", qb.size(), 0);

    // Reset in the middle of a sweep
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (stim_a == 2) break;
      @(negedge clk);
    end
    chk("mid_stim", stim_a, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stim", stim_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_tt", tt_a, 0);
    chk("mid_rst_ttv", ttv_a, 0);
    chk("mid_rst_done", done_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_ttv", ttv_a, 0);
    sweep_a(1'b0);

    // Start pulsed during RUN
    sweep_a(1'b1);

    // Start held high across sweeps
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    e1 = cyc;
    qa.push_back('{tt: 4'b0110, cyc: e1 + 40});
    qa.push_back('{tt: 4'b0110, cyc: e1 + ((LOOP != 0) ? 81 : 82)});
    wait_qa(1, 60);
    repeat (10) @(negedge clk);
    chk("held_ttv_mid", ttv_a, (LOOP != 0) ? 1 : 0);
    chk("held_busy_mid", busy_a, 1);
    start_a = 1'b0;
    wait_qa(0, 60);
    repeat (60) @(negedge clk);
    chk("held_end_busy", busy_a, 0);
    chk("held_end_stim", stim_a, 3);
    chk("held_end_tt", tt_a, 4'b0110);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
